// File: rtl/arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : arb_pkg                                            |
// | Description : Shared types and constants for the four-requester  |
// |               round-robin arbiter.                               |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot grant pattern for each requester
  localparam logic [NUM_REQ-1:0] c_onehot_0 = 4'b0001;
  localparam logic [NUM_REQ-1:0] c_onehot_1 = 4'b0010;
  localparam logic [NUM_REQ-1:0] c_onehot_2 = 4'b0100;
  localparam logic [NUM_REQ-1:0] c_onehot_3 = 4'b1000;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter4_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Interface   : rr_arbiter4_if                                     |
// | Description : Request/grant bundle between the clients and the   |
// |               round-robin arbiter.                               |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic               en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;

  // Client side: drives requests and enable, observes the grant
  modport master (
    output en,
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid
  );

  // Arbiter side
  modport slave (
    input  en,
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid
  );

endinterface : rr_arbiter4_if
`default_nettype wire

// File: rtl/onehot_enc4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : onehot_enc4                                        |
// | Description : 4-bit one-hot to 2-bit index encoder. Any pattern  |
// |               that is not exactly one-hot encodes to zero.       |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module onehot_enc4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx
);

  // Map each legal one-hot pattern to its bit position
  always_comb begin
    idx = '0;
    case (onehot)
      c_onehot_0: idx = IDX_W'(0);
      c_onehot_1: idx = IDX_W'(1);
      c_onehot_2: idx = IDX_W'(2);
      c_onehot_3: idx = IDX_W'(3);
      default:    idx = '0;
    endcase
  end

endmodule : onehot_enc4
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : rr_arbiter4                                        |
// | Description : Four-requester round-robin arbiter with registered |
// |               one-hot and encoded grant and a hold-time limit    |
// |               that forces release of a long-running owner.       |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter4_if.slave  bus
);

  // A one-cycle limit never counts, but keep the counter at least one bit wide
  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(HOLD_MAX - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic [CNT_W-1:0]   w_hold_cnt_next;
  logic [IDX_W-1:0]   r_last_idx;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [IDX_W-1:0]   w_gnt_idx_next;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] w_gnt_next;
  logic [NUM_REQ-1:0] w_pick;
  logic [IDX_W-1:0]   w_scan_idx;
  logic               r_gnt_valid;
  logic               w_issue;
  logic               w_owner_req;

  // Rotating priority: scan from last_idx+1 upward; walking the offsets from
  // farthest to nearest lets the nearest requesting client win the last write.
  always_comb begin
    w_pick     = '0;
    w_scan_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_scan_idx = r_last_idx + IDX_W'(i);
      if (bus.req[w_scan_idx]) begin
        w_pick = NUM_REQ'(1) << w_scan_idx;
      end
    end
  end

  assign w_owner_req = bus.req[r_gnt_idx];

  // Next-state, next-grant and hold counter; only the owner's request matters in GRANT
  always_comb begin
    w_state_next    = r_state;
    w_gnt_next      = r_gnt;
    w_hold_cnt_next = r_hold_cnt;
    w_issue         = 1'b0;
    case (r_state)
      IDLE: begin
        w_gnt_next = '0;
        if (bus.en && (|bus.req)) begin
          w_state_next    = GRANT;
          w_gnt_next      = w_pick;
          w_hold_cnt_next = '0;
          w_issue         = 1'b1;
        end
      end
      GRANT: begin
        if (!bus.en || !w_owner_req || (r_hold_cnt == c_hold_last)) begin
          w_state_next    = IDLE;
          w_gnt_next      = '0;
          w_hold_cnt_next = '0;
        end else begin
          w_hold_cnt_next = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next    = IDLE;
        w_gnt_next      = '0;
        w_hold_cnt_next = '0;
      end
    endcase
  end

  // Index derived from the same next-grant vector that is registered as gnt
  onehot_enc4 u_enc (
    .onehot (w_gnt_next),
    .idx    (w_gnt_idx_next)
  );

  // State, grant outputs and rotation pointer; last_idx moves only on a new grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_hold_cnt  <= '0;
      r_last_idx  <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_state     <= w_state_next;
      r_gnt       <= w_gnt_next;
      r_gnt_idx   <= w_gnt_idx_next;
      r_gnt_valid <= |w_gnt_next;
      r_hold_cnt  <= w_hold_cnt_next;
      if (w_issue) begin
        r_last_idx <= w_gnt_idx_next;
      end
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt_valid = r_gnt_valid;

endmodule : rr_arbiter4
`default_nettype wire
